// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - vectored interrupt controller with rising-edge pending, mask and IDLE/REQ/SERVICE handshake
module intr_ctrl #(
  parameter int              N        = 8,
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] VEC_BASE = 10'h3F0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    irq_in,
  input  logic            mask_we,
  input  logic [N-1:0]    mask_wd,
  input  logic            int_ack,
  input  logic            int_ret,
  output logic            cpu_int,
  output logic [PC_W-1:0] vector,
  output logic            in_service,
  output logic [N-1:0]    pending,
  output logic [N-1:0]    mask_q
);

  localparam int ID_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    mask_d;
  logic [N-1:0]    mask_r_q;
  logic [N-1:0]    prev_q, prev_d;
  logic [ID_W-1:0] cur_id_q, cur_id_d;

  logic [N-1:0]    rise;
  logic [N-1:0]    req;
  logic [N-1:0]    req_iso;
  logic [ID_W-1:0] sel;

  // Lowest-index enabled pending source, isolated as x & -x then encoded
  always_comb begin
    rise    = irq_in & ~prev_q;
    req     = pending_q & mask_r_q;
    req_iso = req & (~req + {{(N-1){1'b0}}, 1'b1});
    sel     = '0;
    for (int i = 0; i < N; i++) begin
      if (req_iso[i]) sel = ID_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_id_d  = cur_id_q;
    pending_d = pending_q;
    mask_d    = mask_we ? mask_wd : mask_r_q;
    prev_d    = irq_in;

    case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d  = REQ;
          cur_id_d = sel;
        end
      end
      REQ: begin
        // Acknowledge wins over a same-edge mask write that would cancel the offer
        if (int_ack) begin
          state_d             = SERVICE;
          pending_d[cur_id_q] = 1'b0;
        end else if (!(pending_q[cur_id_q] & mask_r_q[cur_id_q])) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (int_ret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fresh edge on the acknowledged source re-arms it
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_r_q  <= '0;
      cur_id_q  <= '0;
      prev_q    <= irq_in;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_r_q  <= mask_d;
      cur_id_q  <= cur_id_d;
      prev_q    <= prev_d;
    end
  end

  assign cpu_int    = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign vector     = VEC_BASE + PC_W'(cur_id_q);
  assign pending    = pending_q;
  assign mask_q     = mask_r_q;

endmodule
